// File: rtl/icache_direct_if.sv
// ============================================================================
// Module   : icache_direct_if
// Brief    : Fetch-port and RAM word-port bundle for icache_direct.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_direct_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_inst;
    logic        cpu_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] access_count;
    logic [31:0] miss_count;

    // Cache side
    modport slave (
        input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
        output cpu_inst, cpu_valid, mem_req, mem_addr, access_count, miss_count
    );

    // Core + RAM side
    modport master (
        output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
        input  cpu_inst, cpu_valid, mem_req, mem_addr, access_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
// Module   : icache_direct
// Brief    : Direct-mapped read-only I-cache, 16-byte lines, same-cycle hits,
//            whole-line refill over a req/ack word port.
//            Optional counters enabled by macro ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct #(
    parameter int LINES = 16
) (
    input wire clk,
    input wire rst_n,
    icache_direct_if.slave bus
);

    localparam int IB = $clog2(LINES);
    localparam int TW = 28 - IB;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_fill_tag;
    logic [IB-1:0]     r_fill_index;
    logic [1:0]        r_cnt;
    logic              r_flush_pending;
    logic [LINES-1:0]  r_valid;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;

    logic [TW-1:0]     r_tag  [LINES];
    logic [31:0]       r_data [LINES][4];

    logic [IB-1:0]     w_index;
    logic [TW-1:0]     w_tag;
    logic [1:0]        w_off;
    logic              w_hit;
    logic              w_miss;
    logic              w_wr;
    logic              w_last;
    logic              w_unused;

    assign w_index  = bus.cpu_addr[4+IB-1:4];
    assign w_tag    = bus.cpu_addr[31:4+IB];
    assign w_off    = bus.cpu_addr[3:2];
    assign w_unused = &{1'b0, bus.cpu_addr[1:0]};

    assign w_hit  = (r_state == ST_IDLE) && bus.cpu_req && r_valid[w_index]
                    && (r_tag[w_index] == w_tag);
    assign w_miss = (r_state == ST_IDLE) && bus.cpu_req && !w_hit;
    assign w_wr   = (r_state == ST_REFILL) && bus.mem_ack;
    assign w_last = w_wr && (r_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_fill_tag      <= '0;
            r_fill_index    <= '0;
            r_cnt           <= 2'd0;
            r_flush_pending <= 1'b0;
            r_valid         <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= 32'd0;
        end else begin
            if (bus.flush) begin
                r_valid <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_fill_tag   <= w_tag;
                        r_fill_index <= w_index;
                        r_cnt        <= 2'd0;
                        r_mem_req    <= 1'b1;
                        r_mem_addr   <= {w_tag, w_index, 4'b0000};
                        r_state      <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            // A flush seen at any point of the refill keeps the new line invalid
                            r_valid[r_fill_index] <= !(r_flush_pending || bus.flush);
                            r_flush_pending       <= 1'b0;
                            r_mem_req             <= 1'b0;
                            r_state               <= ST_IDLE;
                        end else begin
                            r_mem_addr <= {r_fill_tag, r_fill_index, r_cnt + 2'd1, 2'b00};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; validity alone gates its use
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_data[r_fill_index][r_cnt] <= bus.mem_rdata;
        end
        if (w_last) begin
            r_tag[r_fill_index] <= r_fill_tag;
        end
    end

    assign bus.cpu_valid = w_hit;
    assign bus.cpu_inst  = w_hit ? r_data[w_index][w_off] : 32'd0;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_access_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_access_count <= 32'd0;
            r_miss_count   <= 32'd0;
        end else begin
            if (w_hit) begin
                r_access_count <= r_access_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign bus.access_count = r_access_count;
    assign bus.miss_count   = r_miss_count;
`else
    assign bus.access_count = 32'd0;
    assign bus.miss_count   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ============================================================================
// Module   : tb_icache_direct
// Brief    : Directed self-checking bench for icache_direct (LINES=16);
//            counter expectations follow macro ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_direct;

    localparam int LINES = 16;
`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_direct_if bus();

    icache_direct #(.LINES(LINES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM contents: a fixed pattern of the word address
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign bus.mem_rdata = data_of(bus.mem_addr);

    int n_assert = 0;
    int n_fail   = 0;
    int exp_acc  = 0;
    int exp_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts();
        chk("access_count", bus.access_count, STATS ? 32'(exp_acc) : 32'd0);
        chk("miss_count",   bus.miss_count,   STATS ? 32'(exp_miss) : 32'd0);
    endtask

    // Called one step after the edge that entered REFILL; returns after the last ack edge
    task automatic refill_words(input logic [31:0] base, input int period, input int flush_word);
        int acked = 0;
        int cyc   = 0;
        while (acked < 4 && cyc < 64) begin
            bus.mem_ack = ((cyc % period) == period - 1);
            bus.flush   = (acked == flush_word);
            #1;
            chk("refill_mem_req",   {31'd0, bus.mem_req},   32'd1);
            chk("refill_mem_addr",  bus.mem_addr,           base + 32'(acked * 4));
            chk("refill_cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
            tick();
            if (bus.mem_ack) acked++;
            cyc++;
        end
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        chk("refill_ack_count", 32'(acked), 32'd4);
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input int period);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        #1;
        chk("miss_cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
        chk("miss_mem_req",   {31'd0, bus.mem_req},   32'd0);
        tick();
        exp_miss++;
        refill_words(addr & ~32'hF, period, -1);
        #1;
        chk("fill_cpu_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("fill_cpu_inst",  bus.cpu_inst,           data_of(addr & ~32'h3));
        chk("fill_mem_req",   {31'd0, bus.mem_req},   32'd0);
        tick();
        exp_acc++;
    endtask

    task automatic fetch_hit(input logic [31:0] addr);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        #1;
        chk("hit_cpu_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("hit_cpu_inst",  bus.cpu_inst,           data_of(addr & ~32'h3));
        chk("hit_mem_req",   {31'd0, bus.mem_req},   32'd0);
        tick();
        exp_acc++;
    endtask

    task automatic idle_cycle();
        bus.cpu_req = 1'b0;
        #1;
        chk("idle_cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
        chk("idle_mem_req",   {31'd0, bus.mem_req},   32'd0);
        tick();
    endtask

    initial begin
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.flush    = 1'b0;
        bus.mem_ack  = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
        chk("rst_mem_addr",  bus.mem_addr,           32'd0);
        chk("rst_cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
        chk("rst_cpu_inst",  bus.cpu_inst,           32'd0);
        chk_counts();
        rst_n = 1'b1;
        tick();
        idle_cycle();

        // Cold miss, then spatial hits
        fetch_miss(32'h0000_0000, 1);
        chk_counts();
        fetch_hit(32'h0000_0004);
        fetch_hit(32'h0000_0008);
        fetch_hit(32'h0000_000C);
        chk_counts();

        // Conflict on index 0
        fetch_hit(32'h0000_0000);
        fetch_miss(32'h0000_0100, 1);
        fetch_hit(32'h0000_0108);
        fetch_miss(32'h0000_0000, 1);
        chk_counts();
        idle_cycle();

        // Backpressure: ack every 3rd cycle
        fetch_miss(32'h0000_0024, 3);
        fetch_hit(32'h0000_0020);
        fetch_hit(32'h0000_002C);
        chk_counts();

        // Flush during the 2nd word of a refill
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0044;
        #1;
        chk("flush_miss_valid", {31'd0, bus.cpu_valid}, 32'd0);
        tick();
        exp_miss++;
        refill_words(32'h0000_0040, 1, 1);
        #1;
        chk("flushed_line_misses", {31'd0, bus.cpu_valid}, 32'd0);
        chk("flushed_line_inst",   bus.cpu_inst,           32'd0);
        tick();
        exp_miss++;
        refill_words(32'h0000_0040, 1, -1);
        #1;
        chk("refetch_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("refetch_inst",  bus.cpu_inst,           data_of(32'h0000_0044));
        tick();
        exp_acc++;
        fetch_miss(32'h0000_0000, 1);
        fetch_miss(32'h0000_0028, 1);
        chk_counts();

        // Flush in IDLE: concurrent hit completes, line invalid afterwards
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0008;
        bus.flush    = 1'b1;
        #1;
        chk("flush_idle_hit_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("flush_idle_hit_inst",  bus.cpu_inst,           data_of(32'h0000_0008));
        tick();
        exp_acc++;
        bus.flush = 1'b0;
        fetch_miss(32'h0000_0008, 1);
        chk_counts();

        // Asynchronous reset after two acks
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0064;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("pre_rst_mem_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("pre_rst_mem_addr", bus.mem_addr,         32'h0000_0068);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("async_rst_mem_addr", bus.mem_addr,         32'd0);
        exp_acc  = 0;
        exp_miss = 0;
        chk_counts();
        tick();
        tick();
        rst_n = 1'b1;
        fetch_miss(32'h0000_0064, 1);
        fetch_hit(32'h0000_0060);
        chk_counts();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
